// File: rtl/bf2_pair_feeder_if.sv
// bf2_pair_feeder_if: sample stream in, butterfly operand pairs out
interface bf2_pair_feeder_if #(parameter int WIDTH = 13, parameter int DEPTH = 2);
   logic                           din_valid;
   logic                           din_sof;
   logic signed [WIDTH*DEPTH-1:0]  din_R;
   logic signed [WIDTH*DEPTH-1:0]  din_Q;
   logic signed [WIDTH*DEPTH-1:0]  dout_R_1;
   logic signed [WIDTH*DEPTH-1:0]  dout_Q_1;
   logic signed [WIDTH*DEPTH-1:0]  dout_R_2;
   logic signed [WIDTH*DEPTH-1:0]  dout_Q_2;
   logic                           dout_en;
   logic                           dout_last;
   logic                           frame_err;
   modport master (
      output din_valid, din_sof, din_R, din_Q,
      input  dout_R_1, dout_Q_1, dout_R_2, dout_Q_2, dout_en, dout_last, frame_err
   );
   modport slave (
      input  din_valid, din_sof, din_R, din_Q,
      output dout_R_1, dout_Q_1, dout_R_2, dout_Q_2, dout_en, dout_last, frame_err
   );
endinterface

// File: rtl/bf2_pair_feeder.sv
// bf2_pair_feeder: buffers the first half-frame and emits x[k] / x[k+N/2] operand pairs
module bf2_pair_feeder #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 2,
   parameter int N     = 16
) (
   input logic              clk,
   input logic              rstn,
   bf2_pair_feeder_if.slave bus
);
   localparam int HALF = N / (2 * DEPTH);
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int VW   = WIDTH * DEPTH;
   typedef enum logic [1:0] {IDLE, FILL, PAIR} state_t;
   state_t        state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt, wr_addr;
   logic          wr, pair, pair_last, abort, cnt_end;
   logic [VW-1:0] mem_r [HALF];
   logic [VW-1:0] mem_q [HALF];
   // next state, counter and buffer write decode; a sof beat always restarts the frame
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      wr        = 1'b0;
      pair      = 1'b0;
      pair_last = 1'b0;
      abort     = 1'b0;
      cnt_end   = (cnt == CW'(HALF - 1));
      wr_addr   = bus.din_sof ? '0 : cnt;
      if (bus.din_valid) begin
         if (bus.din_sof) begin
            wr        = 1'b1;
            abort     = (state != IDLE);
            nxt_state = FILL;
            nxt_cnt   = CW'(1);
         end else if (state == FILL) begin
            wr        = 1'b1;
            nxt_cnt   = cnt_end ? '0 : cnt + 1'b1;
            nxt_state = cnt_end ? PAIR : FILL;
         end else if (state == PAIR) begin
            pair      = 1'b1;
            pair_last = cnt_end;
            nxt_cnt   = cnt_end ? '0 : cnt + 1'b1;
            nxt_state = cnt_end ? IDLE : PAIR;
         end
      end
   end
   // control state and registered operand pairs; pair data holds while no pair is issued
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.dout_R_1  <= '0;
         bus.dout_Q_1  <= '0;
         bus.dout_R_2  <= '0;
         bus.dout_Q_2  <= '0;
         bus.dout_en   <= 1'b0;
         bus.dout_last <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         state         <= nxt_state;
         cnt           <= nxt_cnt;
         bus.dout_en   <= pair;
         bus.dout_last <= pair_last;
         bus.frame_err <= abort;
         if (pair) begin
            bus.dout_R_1 <= mem_r[cnt];
            bus.dout_Q_1 <= mem_q[cnt];
            bus.dout_R_2 <= bus.din_R;
            bus.dout_Q_2 <= bus.din_Q;
         end
      end
   end
   // half-frame buffer, deliberately unreset: every word is written before it is read
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_r[wr_addr] <= bus.din_R;
         mem_q[wr_addr] <= bus.din_Q;
      end
   end
endmodule

// File: tb/tb_bf2_pair_feeder.sv
// tb_bf2_pair_feeder: table vectors, directed corner cases and random frames against a queue model
module tb_bf2_pair_feeder;
   localparam int W    = 13;
   localparam int D    = 2;
   localparam int NN   = 16;
   localparam int HALF = NN / (2 * D);
   localparam int VW   = W * D;
   typedef logic [VW-1:0] vec_t;
   typedef struct {
      logic v;
      logic s;
      int   val;
      logic e;
      logic l;
      int   r1;
      int   r2;
   } rec_t;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t qr[$];
   vec_t qq[$];
   logic m_en, m_last, m_err;
   vec_t m_r1, m_q1, m_r2, m_q2;
   rec_t tbl[$];
   bf2_pair_feeder_if #(.WIDTH(W), .DEPTH(D)) bus ();
   bf2_pair_feeder #(.WIDTH(W), .DEPTH(D), .N(NN)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;
   function automatic vec_t pr(input int b);
      vec_t v;
      for (int l = 0; l < D; l++) v[l*W +: W] = W'(b + l);
      return v;
   endfunction
   function automatic vec_t pq(input int b);
      vec_t v;
      for (int l = 0; l < D; l++) v[l*W +: W] = W'(-(b + l));
      return v;
   endfunction
   task automatic chk(input string name, input vec_t act, input vec_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_clear();
      qr.delete();
      qq.delete();
      m_en = 1'b0; m_last = 1'b0; m_err = 1'b0;
      m_r1 = '0; m_q1 = '0; m_r2 = '0; m_q2 = '0;
   endtask
   task automatic chk_model();
      chk("en", vec_t'(bus.dout_en), vec_t'(m_en));
      chk("last", vec_t'(bus.dout_last), vec_t'(m_last));
      chk("err", vec_t'(bus.frame_err), vec_t'(m_err));
      chk("r1", bus.dout_R_1, m_r1);
      chk("q1", bus.dout_Q_1, m_q1);
      chk("r2", bus.dout_R_2, m_r2);
      chk("q2", bus.dout_Q_2, m_q2);
   endtask
   // one beat: drive at negedge, advance reference model, check at the next negedge
   task automatic step(input logic v, input logic s, input vec_t r, input vec_t q);
      int idx;
      bus.din_valid = v;
      bus.din_sof   = s;
      bus.din_R     = r;
      bus.din_Q     = q;
      m_en = 1'b0; m_last = 1'b0; m_err = 1'b0;
      if (v) begin
         if (s) begin
            m_err = (qr.size() != 0);
            qr.delete();
            qq.delete();
            qr.push_back(r);
            qq.push_back(q);
         end else if (qr.size() != 0) begin
            if (qr.size() >= HALF) begin
               idx  = qr.size() - HALF;
               m_en = 1'b1;
               m_r1 = qr[idx]; m_q1 = qq[idx];
               m_r2 = r;       m_q2 = q;
            end
            qr.push_back(r);
            qq.push_back(q);
            if (qr.size() == 2 * HALF) begin
               m_last = 1'b1;
               qr.delete();
               qq.delete();
            end
         end
      end
      @(negedge clk);
      chk_model();
   endtask
   task automatic beat(input logic s, input int b);
      step(1'b1, s, pr(b), pq(b));
   endtask
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, vec_t'($urandom), vec_t'($urandom));
   endtask
   task automatic frame(input int base);
      for (int w = 0; w < 2 * HALF; w++) beat(w == 0, base + 2 * w);
   endtask
   task automatic chk_zero(input string name);
      chk({name, "_en"}, vec_t'(bus.dout_en), '0);
      chk({name, "_last"}, vec_t'(bus.dout_last), '0);
      chk({name, "_err"}, vec_t'(bus.frame_err), '0);
      chk({name, "_r1"}, bus.dout_R_1, '0);
      chk({name, "_q1"}, bus.dout_Q_1, '0);
      chk({name, "_r2"}, bus.dout_R_2, '0);
      chk({name, "_q2"}, bus.dout_Q_2, '0);
   endtask
   initial begin
      bus.din_valid = 1'b0;
      bus.din_sof   = 1'b0;
      bus.din_R     = '0;
      bus.din_Q     = '0;
      model_clear();
      // contiguous frame, then the same frame with two 3-cycle gaps
      for (int w = 0; w < 8; w++)
         tbl.push_back('{1'b1, w == 0, 2 * w, w >= 4, w == 7, 2 * (w - 4), 2 * w});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0});
      for (int w = 0; w < 3; w++) tbl.push_back('{1'b1, w == 0, 2 * w, 1'b0, 1'b0, 0, 0});
      for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0});
      for (int w = 3; w < 6; w++) tbl.push_back('{1'b1, 1'b0, 2 * w, w >= 4, 1'b0, 2 * (w - 4), 2 * w});
      for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0});
      for (int w = 6; w < 8; w++) tbl.push_back('{1'b1, 1'b0, 2 * w, 1'b1, w == 7, 2 * (w - 4), 2 * w});
      tbl.push_back('{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0});
      repeat (2) @(negedge clk);
      chk_zero("rst");
      rstn = 1'b1;
      @(negedge clk);
      chk_zero("idle");
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].s, pr(tbl[i].val), pq(tbl[i].val));
         chk("tbl_en", vec_t'(bus.dout_en), vec_t'(tbl[i].e));
         chk("tbl_last", vec_t'(bus.dout_last), vec_t'(tbl[i].l));
         if (tbl[i].e) begin
            chk("tbl_r1", bus.dout_R_1, pr(tbl[i].r1));
            chk("tbl_q1", bus.dout_Q_1, pq(tbl[i].r1));
            chk("tbl_r2", bus.dout_R_2, pr(tbl[i].r2));
            chk("tbl_q2", bus.dout_Q_2, pq(tbl[i].r2));
         end
      end
      // beats without sof in IDLE are dropped, next frame pairs cleanly
      for (int i = 0; i < 4; i++) beat(1'b0, 100 + i);
      frame(0);
      // abort in FILL, then abort in PAIR, then a complete frame
      beat(1'b1, 0); beat(1'b0, 2);
      beat(1'b1, 20);
      chk("abort1_err", vec_t'(bus.frame_err), vec_t'(1));
      for (int w = 1; w < 5; w++) beat(1'b0, 20 + 2 * w);
      beat(1'b1, 40);
      chk("abort2_err", vec_t'(bus.frame_err), vec_t'(1));
      chk("abort2_en", vec_t'(bus.dout_en), '0);
      for (int w = 1; w < 8; w++) beat(1'b0, 40 + 2 * w);
      gap(1);
      // back-to-back frames
      frame(0);
      frame(50);
      chk("b2b_r1", bus.dout_R_1, pr(56));
      chk("b2b_r2", bus.dout_R_2, pr(64));
      // asynchronous reset during PAIR beat 1
      for (int w = 0; w < 5; w++) beat(w == 0, 2 * w);
      bus.din_valid = 1'b1; bus.din_sof = 1'b0; bus.din_R = pr(10); bus.din_Q = pq(10);
      #2 rstn = 1'b0;
      #1 chk_zero("arst");
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      gap(2);
      frame(0);
      gap(1);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic v, s;
         v = ($urandom_range(4) != 0);
         s = v && ((qr.size() == 0) ? ($urandom_range(3) != 0) : ($urandom_range(39) == 0));
         step(v, s, vec_t'($urandom), vec_t'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
